cnn_layer_sequencer: RTL and testbench

Top-level layer scheduler for the LeNet-style CNN accelerator. It walks a fixed three-layer conv schedule (conv1+pool, conv2+pool, conv3) and, for every filter, drives three steps through the DMA and the convolution engine: filter load, bias load, then a full feature-map compute. It owns all per-layer configuration: input/output base addresses, input size, pooling flag and global filter number. It sits between the top-level start/finish pins and the DMA/CNN datapath.

---
 rtl/cnn_layer_sequencer.sv | 133 +++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_sequencer.sv
// Walks the fixed three-layer conv schedule, issuing filter load, bias load and compute per filter.
// Owns per-layer configuration (bases, input size, pool flag, global filter number) for the DMA and engine.
module cnn_layer_sequencer #(
  parameter logic [15:0] IMG_BASE    = 16'd0,
  parameter logic [15:0] BUF_A       = 16'd2048,
  parameter logic [15:0] BUF_B       = 16'd4096,
  parameter logic [15:0] RESULT_BASE = 16'd6144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        finish,
  output logic        busy,
  output logic [1:0]  layer_idx,
  output logic        dma_start,
  output logic [1:0]  dma_op,
  output logic [15:0] dma_filter_number,
  input  logic        dma_finish,
  output logic        eng_start,
  output logic [15:0] eng_in_base,
  output logic [15:0] eng_out_base,
  output logic [5:0]  eng_in_size,
  output logic        eng_pool,
  input  logic        eng_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_FILT, S_WAIT_FILT, S_LOAD_BIAS, S_WAIT_BIAS,
    S_RUN, S_WAIT_RUN, S_NEXT, S_DONE
  } state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_layer;
  logic [6:0]  r_f_local;
  logic [7:0]  r_global;
  logic [15:0] r_in_base, r_out_base;
  logic [5:0]  r_in_size;
  logic        r_pool;
  logic [1:0]  r_dma_op;
  logic        w_last_filt;
  logic [15:0] w_stride;

  always_comb begin
    w_last_filt = 1'b0;
    w_stride    = 16'd1;
    case (r_layer)
      2'd0: begin w_last_filt = (r_f_local == 7'd5);   w_stride = 16'd196; end
      2'd1: begin w_last_filt = (r_f_local == 7'd15);  w_stride = 16'd25;  end
      default: begin w_last_filt = (r_f_local == 7'd119); w_stride = 16'd1; end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (start) w_next = S_LOAD_FILT;
      S_LOAD_FILT: w_next = S_WAIT_FILT;
      S_WAIT_FILT: if (dma_finish) w_next = S_LOAD_BIAS;
      S_LOAD_BIAS: w_next = S_WAIT_BIAS;
      S_WAIT_BIAS: if (dma_finish) w_next = S_RUN;
      S_RUN:       w_next = S_WAIT_RUN;
      S_WAIT_RUN:  if (eng_done) w_next = S_NEXT;
      S_NEXT:      w_next = (w_last_filt && r_layer == 2'd2) ? S_DONE : S_LOAD_FILT;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Counters and config change only at run start and in NEXT, so they hold for a whole filter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_layer    <= 2'd0;
      r_f_local  <= 7'd0;
      r_global   <= 8'd0;
      r_in_base  <= IMG_BASE;
      r_out_base <= BUF_A;
      r_in_size  <= 6'd32;
      r_pool     <= 1'b0;
      r_dma_op   <= 2'b00;
    end else begin
      if (w_next == S_LOAD_FILT)      r_dma_op <= 2'b10;
      else if (w_next == S_LOAD_BIAS) r_dma_op <= 2'b11;

      if (r_state == S_IDLE && start) begin
        r_layer    <= 2'd0;
        r_f_local  <= 7'd0;
        r_global   <= 8'd0;
        r_in_base  <= IMG_BASE;
        r_out_base <= BUF_A;
        r_in_size  <= 6'd32;
        r_pool     <= 1'b1;
      end else if (r_state == S_NEXT && !(w_last_filt && r_layer == 2'd2)) begin
        r_global <= r_global + 8'd1;
        if (w_last_filt) begin
          r_layer   <= r_layer + 2'd1;
          r_f_local <= 7'd0;
          if (r_layer == 2'd0) begin
            r_in_base  <= BUF_A;
            r_out_base <= BUF_B;
            r_in_size  <= 6'd14;
            r_pool     <= 1'b1;
          end else begin
            r_in_base  <= BUF_B;
            r_out_base <= RESULT_BASE;
            r_in_size  <= 6'd5;
            r_pool     <= 1'b0;
          end
        end else begin
          r_f_local  <= r_f_local + 7'd1;
          r_out_base <= r_out_base + w_stride;
        end
      end
    end
  end

  assign busy              = (r_state != S_IDLE);
  assign finish            = (r_state == S_DONE);
  assign dma_start         = (r_state == S_LOAD_FILT) || (r_state == S_LOAD_BIAS);
  assign eng_start         = (r_state == S_RUN);
  assign dma_op            = r_dma_op;
  assign dma_filter_number = {8'd0, r_global};
  assign layer_idx         = r_layer;
  assign eng_in_base       = r_in_base;
  assign eng_out_base      = r_out_base;
  assign eng_in_size       = r_in_size;
  assign eng_pool          = r_pool;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Scoreboard bench for cnn_layer_sequencer: a layer-table model predicts the request stream,
// randomized-latency responders answer the DMA and engine, and a monitor checks each pulse.
module tb_cnn_layer_sequencer;
  localparam logic [15:0] IMG = 16'd0, BA = 16'd2048, BB = 16'd4096, RB = 16'd6144;

  logic clk, reset, start;
  logic finish, busy, dma_start, eng_start, eng_pool, dma_finish, eng_done;
  logic [1:0] layer_idx, dma_op;
  logic [15:0] dfn, in_b, out_b;
  logic [5:0] in_size;
  logic resp_dma = 0, inj_dma = 0, tog_dma = 0, resp_eng = 0, stray_eng = 0, tog_eng = 0;

  assign dma_finish = resp_dma | inj_dma | tog_dma;
  assign eng_done   = resp_eng | stray_eng | tog_eng;

  cnn_layer_sequencer #(.IMG_BASE(IMG), .BUF_A(BA), .BUF_B(BB), .RESULT_BASE(RB)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish), .busy(busy),
    .layer_idx(layer_idx), .dma_start(dma_start), .dma_op(dma_op),
    .dma_filter_number(dfn), .dma_finish(dma_finish), .eng_start(eng_start),
    .eng_in_base(in_b), .eng_out_base(out_b), .eng_in_size(in_size),
    .eng_pool(eng_pool), .eng_done(eng_done)
  );

  typedef struct packed {
    logic [3:0]  kind;   // 0 filter load, 1 bias load, 2 engine start, 3 finish
    logic [15:0] num;
    logic [15:0] ib;
    logic [15:0] ob;
    logic [5:0]  sz;
    logic        pool;
    logic [1:0]  layer;
  } ev_t;

  ev_t sbq[$];
  int  n_checks = 0, n_fail = 0, cyc = 0, start_c = 0, n_finish = 0;
  int  dly_lo = 0, dly_hi = 0;
  bit  inject = 0, chk_cyc = 0, outstanding = 0;

  int l_in[3]     = '{0, 2048, 4096};
  int l_size[3]   = '{32, 14, 5};
  int l_nf[3]     = '{6, 16, 120};
  int l_pool[3]   = '{1, 1, 0};
  int l_out[3]    = '{2048, 4096, 6144};
  int l_stride[3] = '{196, 25, 1};

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_ev(input ev_t a, input ev_t e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL event: got kind %0d num %0d in %0d out %0d size %0d pool %0d layer %0d, expected kind %0d num %0d in %0d out %0d size %0d pool %0d layer %0d",
               a.kind, a.num, a.ib, a.ob, a.sz, a.pool, a.layer,
               e.kind, e.num, e.ib, e.ob, e.sz, e.pool, e.layer);
    end
  endtask

  // Expected request stream straight from the layer table.
  task automatic build_expected();
    int g;
    ev_t e;
    g = 0;
    sbq.delete();
    for (int l = 0; l < 3; l++) begin
      for (int f = 0; f < l_nf[l]; f++) begin
        e = '0; e.kind = 4'd0; e.num = 16'(g); sbq.push_back(e);
        e = '0; e.kind = 4'd1; e.num = 16'(g); sbq.push_back(e);
        e.kind = 4'd2; e.ib = 16'(l_in[l]); e.ob = 16'(l_out[l] + f * l_stride[l]);
        e.sz = 6'(l_size[l]); e.pool = 1'(l_pool[l]); e.layer = 2'(l);
        sbq.push_back(e);
        g++;
      end
    end
    e = '0; e.kind = 4'd3; sbq.push_back(e);
  endtask

  task automatic check_reset_outs(input string name);
    logic [62:0] act, exp;
    act = {busy, finish, dma_start, eng_start, eng_pool, dma_op, dfn, layer_idx, in_b, out_b, in_size};
    exp = {5'b0, 2'b00, 16'd0, 2'd0, IMG, BA, 6'd32};
    check(name, longint'(act), longint'(exp));
  endtask

  // Monitor: every request/finish pulse pops the scoreboard.
  initial begin
    ev_t a, e;
    int npulse;
    forever begin
      @(negedge clk);
      if (!reset) outstanding = 0;
      else begin
        if (resp_dma || resp_eng) outstanding = 0;
        npulse = int'(dma_start) + int'(eng_start) + int'(finish);
        if (npulse != 0) begin
          a = '0;
          if (npulse > 1) a.kind = 4'd8;
          else if (finish) a.kind = 4'd3;
          else if (eng_start) begin
            a.kind = 4'd2; a.num = dfn; a.ib = in_b; a.ob = out_b;
            a.sz = in_size; a.pool = eng_pool; a.layer = layer_idx;
          end else begin
            a.kind = (dma_op == 2'b10) ? 4'd0 : (dma_op == 2'b11) ? 4'd1 : 4'd9;
            a.num = dfn;
          end
          if (a.kind != 4'd3) begin
            check("single_outstanding", longint'(outstanding), 0);
            outstanding = 1;
          end else begin
            n_finish++;
            if (chk_cyc) check("finish_cycle", cyc, start_c + 995);
          end
          if (sbq.size() == 0) check("unexpected_event", a.kind, -1);
          else begin
            e = sbq.pop_front();
            check_ev(a, e);
          end
        end
      end
    end
  end

  // DMA responder; optionally injects a pulse coincident with the request and a stray eng_done.
  initial begin
    int d;
    bit is_filt;
    forever begin
      @(negedge clk);
      if (reset && dma_start) begin
        d = $urandom_range(dly_hi, dly_lo);
        is_filt = (dma_op == 2'b10);
        if (inject && is_filt) inj_dma = 1;
        @(posedge clk); #1 inj_dma = 0;
        if (inject && !is_filt) begin
          stray_eng = 1;
          @(posedge clk); #1 stray_eng = 0;
          if (d > 0) d = d - 1;
        end
        repeat (d) begin @(posedge clk); #1; end
        resp_dma = 1;
        @(posedge clk); #1 resp_dma = 0;
      end
    end
  end

  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (reset && eng_start) begin
        d = $urandom_range(dly_hi, dly_lo);
        @(posedge clk); #1;
        repeat (d) begin @(posedge clk); #1; end
        resp_eng = 1;
        @(posedge clk); #1 resp_eng = 0;
      end
    end
  end

  task automatic run_net(input bit hold, input bit timing);
    int t, f0;
    build_expected();
    chk_cyc = timing;
    f0 = n_finish;
    @(posedge clk); #1 start = 1; start_c = cyc;
    @(posedge clk); #1 if (!hold) start = 0;
    @(negedge clk);
    check("first_cycle", longint'({busy, dma_start, dma_op}), 4'b1110);
    if (hold) begin repeat (300) @(posedge clk); #1 start = 0; end
    t = 0;
    while (n_finish == f0 && t < 20000) begin @(negedge clk); t++; end
    check("finish_count", n_finish - f0, 1);
    @(negedge clk);
    check("busy_drop", longint'(busy), 0);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);
  endtask

  initial begin
    int t;
    reset = 0; start = 0;
    repeat (6) begin
      @(posedge clk); #1 start = ~start; tog_dma = ~tog_dma; tog_eng = 1'($urandom_range(1, 0));
      @(negedge clk); check_reset_outs("reset_hold");
    end
    start = 0; tog_dma = 0; tog_eng = 0;
    @(posedge clk); #1 reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk); check_reset_outs("after_release");

    dly_lo = 0; dly_hi = 0; inject = 0;
    run_net(0, 1);

    dly_lo = 3; dly_hi = 10; inject = 1;
    run_net(1, 0);

    build_expected();
    chk_cyc = 0;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    t = 0;
    while (!(eng_start && dfn == 16'd30) && t < 5000) begin @(negedge clk); t++; end
    check("reached_g30", longint'(eng_start && dfn == 16'd30), 1);
    @(negedge clk);
    check("in_wait_run", longint'({busy, eng_start, dma_start}), 3'b100);
    #1 reset = 0;
    #1 check_reset_outs("mid_run_reset");
    sbq.delete();
    repeat (5) begin @(negedge clk); check("no_finish_in_reset", longint'(finish), 0); end
    @(posedge clk); #1 reset = 1;
    repeat (20) @(posedge clk);
    @(negedge clk); check_reset_outs("idle_after_abort");

    dly_lo = 0; dly_hi = 0; inject = 0;
    run_net(0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    check("watchdog", 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
